regfile_mp: RTL

Parametrised multi-port general-purpose register file for the OpenMIPS pipeline. It provides NUM_RD synchronous read ports, two write ports and write-to-read bypass. A per-register busy scoreboard lets the decode stage see whether a read operand is final or still owed by an in-flight producer. It sits between ID (reads and busy-set) and WB (two retire lanes), and is the dual-issue replacement for the single-write register file.

---
 rtl/regfile_mp.sv | 88 ++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with two write lanes, write-to-read bypass and a
// per-register busy scoreboard so decode can tell final operands from owed ones.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rvalid,
  input  logic                       busy_set,
  input  logic [ADDR_W-1:0]          busy_addr,
  output logic [(1<<ADDR_W)-1:0]     busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0]        mem_reg  [DEPTH];
  logic [DATA_W-1:0]        mem_next [DEPTH];
  logic [DEPTH-1:0]         busy_reg, busy_next;
  logic [NUM_RD*DATA_W-1:0] rdata_reg, rdata_next;
  logic [NUM_RD-1:0]        rvalid_reg, rvalid_next;
  logic                     wr_en0, wr_en1, set_en;

  // Writes (and busy marks) aimed at a hardwired zero register are dropped here,
  // so neither the array, the scoreboard nor the bypass ever sees them.
  assign wr_en0 = we0 && !(HAS_ZERO && (waddr0 == '0));
  assign wr_en1 = we1 && !(HAS_ZERO && (waddr1 == '0));
  assign set_en = busy_set && !(HAS_ZERO && (busy_addr == '0));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic hit0, hit1, set_hit;
      assign hit0    = wr_en0 && (waddr0 == ADDR_W'(gi));
      assign hit1    = wr_en1 && (waddr1 == ADDR_W'(gi));
      assign set_hit = set_en && (busy_addr == ADDR_W'(gi));
      // Lane 1 is the younger instruction and overrides lane 0 on a conflict.
      assign mem_next[gi]  = hit1 ? wdata1 : (hit0 ? wdata0 : mem_reg[gi]);
      assign busy_next[gi] = set_hit | (busy_reg[gi] & ~(hit0 | hit1));
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              rd_zero, fwd0, fwd1;
      assign ra      = raddr[gi*ADDR_W +: ADDR_W];
      assign rd_zero = HAS_ZERO && (ra == '0);
      assign fwd0    = wr_en0 && (waddr0 == ra);
      assign fwd1    = wr_en1 && (waddr1 == ra);
      assign rdata_next[gi*DATA_W +: DATA_W] =
          (!re[gi] || rd_zero) ? '0 :
          fwd1                 ? wdata1 :
          fwd0                 ? wdata0 :
                                 mem_reg[ra];
      // Busy is sampled pre-update; only a same-cycle write hit overrides it.
      assign rvalid_next[gi] = re[gi] && (rd_zero || fwd0 || fwd1 || !busy_reg[ra]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      busy_reg   <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= mem_next[i];
      busy_reg   <= busy_next;
      rdata_reg  <= rdata_next;
      rvalid_reg <= rvalid_next;
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign busy   = busy_reg;

endmodule
